game_sequencer: RTL and testbench

Parametrised game-flow controller that replaces the ad-hoc tick gating and failure/success latching at the snake top level. It owns the game state machine, lives, speed level, BCD score and the vsync-derived move tick. It sits between control/snake/apple and the vga/sound blocks. The top level drives sub-block resets from o_game_rst.

---
 rtl/game_sequencer_pkg.sv | 17 +
 rtl/game_sequencer_bcd_counter.sv | 60 ++++++
 rtl/game_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_game_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared types for the game-flow controller: state encoding and BCD digit type.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSE   = 3'd2,
        RESPAWN = 3'd3,
        OVER    = 3'd4,
        WIN     = 3'd5
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/game_sequencer_bcd_counter.sv
// Multi-digit BCD counter with synchronous clear, saturating increment and a
// greater-than comparison against an external BCD value.
module bcd_counter
    import game_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  inc,
    input  logic [4*DIGITS-1:0]   cmp_value,
    output logic [4*DIGITS-1:0]   value,
    output logic                  gt
);

    logic [4*DIGITS-1:0] next_value;

    // Ripple a +1 through the digits; an all-nines value stays where it is.
    always_comb begin
        logic carry;
        next_value = value;
        carry      = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (value[4*d +: 4] == BCD_MAX) begin
                    next_value[4*d +: 4] = 4'd0;
                end else begin
                    next_value[4*d +: 4] = value[4*d +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
        if (carry) begin
            next_value = value;
        end
    end

    // Most significant differing digit decides the comparison.
    always_comb begin
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (!decided && (value[4*d +: 4] != cmp_value[4*d +: 4])) begin
                gt      = (value[4*d +: 4] > cmp_value[4*d +: 4]);
                decided = 1'b1;
            end
        end
    end

    // Counter register: clear has priority over increment.
    always_ff @(posedge clk) begin
        if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: state machine, lives, speed level, BCD score and the
// vsync-derived move tick. Optional high-score register is built when
// GAME_SEQUENCER_HIGHSCORE_EN is defined; otherwise o_highscore is tied to 0.
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES            = 3,
    parameter int NUM_LEVELS       = 8,
    parameter int START_LEVEL      = 2,
    parameter int MAX_PERIOD       = 30,
    parameter int PERIOD_STEP      = 3,
    parameter int APPLES_PER_LEVEL = 5,
    parameter int SCORE_DIGITS     = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_restart,
    input  logic                            i_start,
    input  logic                            i_pause,
    input  logic                            i_vsync,
    input  logic                            i_tick_done,
    input  logic                            i_eat,
    input  logic                            i_failure,
    input  logic                            i_success,
    input  logic                            i_speed_up,
    input  logic                            i_speed_down,
    output logic                            o_tick,
    output state_t                          o_state,
    output logic                            o_game_rst,
    output logic [$clog2(LIVES+1)-1:0]      o_lives,
    output logic [$clog2(NUM_LEVELS)-1:0]   o_level,
    output logic [4*SCORE_DIGITS-1:0]       o_score,
    output logic                            o_failure,
    output logic                            o_success,
    output logic [4*SCORE_DIGITS-1:0]       o_highscore
);

    localparam int LW = $clog2(LIVES + 1);
    localparam int VW = $clog2(NUM_LEVELS);
    localparam int FW = $clog2(MAX_PERIOD + 1);
    localparam int EW = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;
    localparam logic [VW-1:0] LEVEL_MAX = VW'(NUM_LEVELS - 1);

    state_t        state;
    logic          vsync_q;
    logic          vsync_edge;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] period;
    logic [EW-1:0] eat_cnt;
    logic [VW-1:0] next_level;
    logic          rst_tail;
    logic          restart_any;
    logic          eat_inc;
    logic          auto_up;

    assign o_state     = state;
    assign restart_any = !rst_n || i_restart;
    assign vsync_edge  = i_vsync && !vsync_q;
    assign eat_inc     = i_eat && ((state == RUN) || (state == PAUSE));
    assign auto_up     = eat_inc && (APPLES_PER_LEVEL != 0) &&
                         (eat_cnt == EW'(APPLES_PER_LEVEL - 1));

    // Single-register vsync edge detector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= i_vsync;
        end
    end

    // Frames per move shrink with level, never below one frame.
    always_comb begin
        int reduction;
        reduction = int'(level_ext()) * PERIOD_STEP;
        if (reduction >= MAX_PERIOD - 1) begin
            period = FW'(1);
        end else begin
            period = FW'(MAX_PERIOD - reduction);
        end
    end

    function automatic logic [VW-1:0] level_ext();
        return o_level;
    endfunction

    // Auto speed-up wins over manual control; manual only applies in IDLE/RUN.
    always_comb begin
        next_level = o_level;
        if (auto_up) begin
            if (o_level != LEVEL_MAX) begin
                next_level = o_level + VW'(1);
            end
        end else if (((state == IDLE) || (state == RUN)) && (i_speed_up ^ i_speed_down)) begin
            if (i_speed_up && (o_level != LEVEL_MAX)) begin
                next_level = o_level + VW'(1);
            end else if (i_speed_down && (o_level != '0)) begin
                next_level = o_level - VW'(1);
            end
        end
    end

    // Game state machine with lives, level, move tick and reset pulse.
    always_ff @(posedge clk) begin
        if (restart_any) begin
            state      <= IDLE;
            o_lives    <= LW'(LIVES);
            o_level    <= VW'(START_LEVEL);
            frame_cnt  <= '0;
            eat_cnt    <= '0;
            o_tick     <= 1'b0;
            o_failure  <= 1'b0;
            o_success  <= 1'b0;
            o_game_rst <= 1'b1;
            rst_tail   <= 1'b1;
        end else begin
            rst_tail   <= 1'b0;
            o_game_rst <= rst_tail;
            o_level    <= next_level;

            if (eat_inc && (APPLES_PER_LEVEL != 0)) begin
                eat_cnt <= auto_up ? '0 : eat_cnt + EW'(1);
            end

            if (o_tick) begin
                if (i_tick_done) begin
                    o_tick <= 1'b0;
                end
            end else if (state == RUN) begin
                if (frame_cnt >= period) begin
                    o_tick    <= 1'b1;
                    frame_cnt <= '0;
                end else if (vsync_edge) begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
            if (state != RUN) begin
                frame_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (i_failure) begin
                        if (o_lives > LW'(1)) begin
                            o_lives    <= o_lives - LW'(1);
                            state      <= RESPAWN;
                            o_game_rst <= 1'b1;
                        end else begin
                            o_lives   <= '0;
                            state     <= OVER;
                            o_failure <= 1'b1;
                        end
                    end else if (i_success) begin
                        state     <= WIN;
                        o_success <= 1'b1;
                    end else if (i_pause) begin
                        state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (!i_pause) begin
                        state <= RUN;
                    end
                end
                RESPAWN: state <= IDLE;
                OVER, WIN: state <= state;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GAME_SEQUENCER_HIGHSCORE_EN
    logic [4*SCORE_DIGITS-1:0] highscore;
    logic                      score_gt;
    logic                      end_entry;

    assign end_entry   = !i_restart && (state == RUN) &&
                         (i_failure ? (o_lives <= LW'(1)) : i_success);
    assign o_highscore = highscore;

    bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score (
        .clk       (clk),
        .clear     (restart_any),
        .inc       (eat_inc),
        .cmp_value (highscore),
        .value     (o_score),
        .gt        (score_gt)
    );

    // High score survives restarts and captures a better score at game end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            highscore <= '0;
        end else if (end_entry && score_gt) begin
            highscore <= o_score;
        end
    end
`else
    logic unused_score_gt;

    assign o_highscore = '0;

    bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score (
        .clk       (clk),
        .clear     (restart_any),
        .inc       (eat_inc),
        .cmp_value ('0),
        .value     (o_score),
        .gt        (unused_score_gt)
    );
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer with default parameters.
module tb_game_sequencer;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_restart, i_start, i_pause, i_vsync, i_tick_done;
    logic        i_eat, i_failure, i_success, i_speed_up, i_speed_down;
    logic        o_tick, o_game_rst, o_failure, o_success;
    state_t      o_state;
    logic [1:0]  o_lives;
    logic [2:0]  o_level;
    logic [11:0] o_score, o_highscore;

    int checks = 0;
    int passes = 0;

    game_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_restart    (i_restart),
        .i_start      (i_start),
        .i_pause      (i_pause),
        .i_vsync      (i_vsync),
        .i_tick_done  (i_tick_done),
        .i_eat        (i_eat),
        .i_failure    (i_failure),
        .i_success    (i_success),
        .i_speed_up   (i_speed_up),
        .i_speed_down (i_speed_down),
        .o_tick       (o_tick),
        .o_state      (o_state),
        .o_game_rst   (o_game_rst),
        .o_lives      (o_lives),
        .o_level      (o_level),
        .o_score      (o_score),
        .o_failure    (o_failure),
        .o_success    (o_success),
        .o_highscore  (o_highscore)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic vsyncEdges(input int n);
        repeat (n) begin
            i_vsync = 1'b1;
            applyStimulus(2);
            i_vsync = 1'b0;
            applyStimulus(2);
        end
    endtask

    task automatic eatPulses(input int n);
        repeat (n) begin
            i_eat = 1'b1;
            applyStimulus(1);
            i_eat = 1'b0;
            applyStimulus(1);
        end
    endtask

    task automatic tickDone();
        i_tick_done = 1'b1;
        applyStimulus(1);
        i_tick_done = 1'b0;
    endtask

    task automatic pulseFailure();
        i_failure = 1'b1;
        applyStimulus(1);
        i_failure = 1'b0;
    endtask

    task automatic pulseSpeed(input logic up, input logic down, input int n);
        repeat (n) begin
            i_speed_up   = up;
            i_speed_down = down;
            applyStimulus(1);
            i_speed_up   = 1'b0;
            i_speed_down = 1'b0;
        end
    endtask

    task automatic doRestart();
        i_start   = 1'b0;
        i_restart = 1'b1;
        applyStimulus(1);
        i_restart = 1'b0;
        applyStimulus(2);
    endtask

    initial begin
        rst_n = 1'b0; i_restart = 1'b0; i_start = 1'b0; i_pause = 1'b0;
        i_vsync = 1'b0; i_tick_done = 1'b0; i_eat = 1'b0; i_failure = 1'b0;
        i_success = 1'b0; i_speed_up = 1'b0; i_speed_down = 1'b0;
        $display("[TB] game_sequencer directed test");

        applyStimulus(2);
        checkOutput("reset_state", 32'(o_state), 32'(IDLE));
        checkOutput("reset_game_rst", 32'(o_game_rst), 32'd1);
        checkOutput("reset_lives", 32'(o_lives), 32'd3);
        checkOutput("reset_level", 32'(o_level), 32'd2);
        checkOutput("reset_score", 32'(o_score), 32'h000);
        checkOutput("reset_tick", 32'(o_tick), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1);
        checkOutput("game_rst_tail", 32'(o_game_rst), 32'd1);
        applyStimulus(1);
        checkOutput("game_rst_end", 32'(o_game_rst), 32'd0);

        i_start = 1'b1;
        applyStimulus(1);
        checkOutput("start_run", 32'(o_state), 32'(RUN));
        vsyncEdges(23);
        checkOutput("tick_23_edges", 32'(o_tick), 32'd0);
        vsyncEdges(1);
        checkOutput("tick_24_edges", 32'(o_tick), 32'd1);
        applyStimulus(2);
        checkOutput("tick_held", 32'(o_tick), 32'd1);
        tickDone();
        checkOutput("tick_cleared", 32'(o_tick), 32'd0);

        eatPulses(5);
        checkOutput("score_5", 32'(o_score), 32'h005);
        checkOutput("auto_level_3", 32'(o_level), 32'd3);
        vsyncEdges(20);
        checkOutput("tick_20_edges", 32'(o_tick), 32'd0);
        vsyncEdges(1);
        checkOutput("tick_21_edges", 32'(o_tick), 32'd1);
        tickDone();

        i_pause = 1'b1;
        applyStimulus(1);
        checkOutput("pause_state", 32'(o_state), 32'(PAUSE));
        eatPulses(1);
        checkOutput("pause_eat", 32'(o_score), 32'h006);
        pulseSpeed(1'b1, 1'b0, 1);
        checkOutput("pause_no_speed", 32'(o_level), 32'd3);
        pulseFailure();
        checkOutput("pause_fail_ign", 32'(o_state), 32'(PAUSE));
        checkOutput("pause_lives", 32'(o_lives), 32'd3);
        i_pause = 1'b0;
        applyStimulus(1);
        checkOutput("resume_run", 32'(o_state), 32'(RUN));

        pulseFailure();
        checkOutput("fail1_state", 32'(o_state), 32'(RESPAWN));
        checkOutput("fail1_lives", 32'(o_lives), 32'd2);
        checkOutput("fail1_game_rst", 32'(o_game_rst), 32'd1);
        checkOutput("fail1_score", 32'(o_score), 32'h006);
        checkOutput("fail1_level", 32'(o_level), 32'd3);
        applyStimulus(1);
        checkOutput("respawn_idle", 32'(o_state), 32'(IDLE));
        checkOutput("respawn_rst_end", 32'(o_game_rst), 32'd0);
        applyStimulus(1);
        checkOutput("respawn_run", 32'(o_state), 32'(RUN));
        pulseFailure();
        checkOutput("fail2_state", 32'(o_state), 32'(RESPAWN));
        checkOutput("fail2_lives", 32'(o_lives), 32'd1);
        applyStimulus(2);
        i_failure = 1'b1;
        i_success = 1'b1;
        applyStimulus(1);
        i_failure = 1'b0;
        i_success = 1'b0;
        checkOutput("fail3_state", 32'(o_state), 32'(OVER));
        checkOutput("fail3_lives", 32'(o_lives), 32'd0);
        checkOutput("fail3_failure", 32'(o_failure), 32'd1);
        checkOutput("fail3_success", 32'(o_success), 32'd0);
        vsyncEdges(30);
        checkOutput("over_no_tick", 32'(o_tick), 32'd0);
        checkOutput("over_held", 32'(o_state), 32'(OVER));

        i_start   = 1'b0;
        i_restart = 1'b1;
        applyStimulus(1);
        checkOutput("restart_state", 32'(o_state), 32'(IDLE));
        checkOutput("restart_lives", 32'(o_lives), 32'd3);
        checkOutput("restart_score", 32'(o_score), 32'h000);
        checkOutput("restart_level", 32'(o_level), 32'd2);
        checkOutput("restart_failure", 32'(o_failure), 32'd0);
        checkOutput("restart_game_rst", 32'(o_game_rst), 32'd1);
        i_restart = 1'b0;
        applyStimulus(2);
        checkOutput("restart_rst_end", 32'(o_game_rst), 32'd0);

        pulseSpeed(1'b1, 1'b0, 10);
        checkOutput("idle_up_sat", 32'(o_level), 32'd7);
        pulseSpeed(1'b1, 1'b1, 1);
        checkOutput("idle_both", 32'(o_level), 32'd7);
        pulseSpeed(1'b0, 1'b1, 1);
        checkOutput("idle_down", 32'(o_level), 32'd6);
        pulseSpeed(1'b0, 1'b1, 10);
        checkOutput("idle_down_sat", 32'(o_level), 32'd0);

        i_start = 1'b1;
        applyStimulus(1);
        i_success = 1'b1;
        applyStimulus(1);
        i_success = 1'b0;
        checkOutput("win_state", 32'(o_state), 32'(WIN));
        checkOutput("win_success", 32'(o_success), 32'd1);
        checkOutput("win_failure", 32'(o_failure), 32'd0);
        pulseFailure();
        checkOutput("win_held", 32'(o_state), 32'(WIN));
        checkOutput("win_lives", 32'(o_lives), 32'd3);

        doRestart();
        i_start = 1'b1;
        applyStimulus(1);
        eatPulses(4);
        i_eat        = 1'b1;
        i_speed_down = 1'b1;
        applyStimulus(1);
        i_eat        = 1'b0;
        i_speed_down = 1'b0;
        checkOutput("auto_beats_manual", 32'(o_level), 32'd3);
        checkOutput("score_5b", 32'(o_score), 32'h005);

        eatPulses(1000);
        checkOutput("score_sat", 32'(o_score), 32'h999);
        checkOutput("level_sat", 32'(o_level), 32'd7);
        pulseSpeed(1'b0, 1'b1, 1);
        checkOutput("run_down", 32'(o_level), 32'd6);
        pulseSpeed(1'b1, 1'b1, 1);
        checkOutput("run_both", 32'(o_level), 32'd6);
        pulseSpeed(1'b1, 1'b0, 2);
        checkOutput("run_up_sat", 32'(o_level), 32'd7);
        vsyncEdges(8);
        checkOutput("tick_8_edges", 32'(o_tick), 32'd0);
        vsyncEdges(1);
        checkOutput("tick_9_edges", 32'(o_tick), 32'd1);
        tickDone();

`ifdef GAME_SEQUENCER_HIGHSCORE_EN
        doRestart();
        i_start = 1'b1;
        applyStimulus(1);
        eatPulses(12);
        i_success = 1'b1;
        applyStimulus(1);
        i_success = 1'b0;
        checkOutput("hs_load", 32'(o_highscore), 32'h012);
        doRestart();
        checkOutput("hs_keep_restart", 32'(o_highscore), 32'h012);
        i_start = 1'b1;
        applyStimulus(1);
        eatPulses(7);
        i_success = 1'b1;
        applyStimulus(1);
        i_success = 1'b0;
        checkOutput("hs_no_lower", 32'(o_highscore), 32'h012);
        rst_n = 1'b0;
        applyStimulus(1);
        rst_n = 1'b1;
        applyStimulus(2);
        checkOutput("hs_rst_clear", 32'(o_highscore), 32'h000);
`else
        checkOutput("hs_tied_zero", 32'(o_highscore), 32'h000);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
